// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-PC generator: flush causes, FSM state
// codes and the default boot address.
package pc_gen_pkg;

  localparam logic FC_EXCEPTION  = 1'b0;
  localparam logic FC_MISPREDICT = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  localparam logic [31:0] PC_ENTRY_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/pc_gen_multi_sat_counter.sv
// Saturating up-counter that sticks at all-ones, with async reset and
// synchronous clear.
module sat_counter
  import pc_gen_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_gen_multi.sv
// Fetch-PC generator: holds the fetch-group address, handshakes with the
// icache, selects the next PC by redirect priority, keeps branch counters.
module pc_gen_multi
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                FETCH_W  = 2,
  parameter logic [ADDR_W-1:0] ENTRY    = ADDR_W'(PC_ENTRY_DEFAULT),
  parameter int                CNT_W    = 32,
  parameter int                DS_SLOTS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              flush_cause,
  input  logic [ADDR_W-1:0] epc,
  input  logic              resolve_valid,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] npc_actual,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              ibuffer_full,
  input  logic              icache_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              rreq_to_icache,
  output logic [FETCH_W-1:0] fetch_mask,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  hit_count
);

  localparam logic [ADDR_W-1:0] GROUP_BYTES = ADDR_W'(4 * FETCH_W);
  localparam logic [ADDR_W-1:0] NT_OFFSET   = ADDR_W'(4 * (1 + DS_SLOTS));
  localparam logic [ADDR_W-1:0] SLOT_MASK   = ADDR_W'(FETCH_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_slot;
  logic [FETCH_W-1:0] w_mask;
  logic              w_rreq;
  logic              w_hs;
  logic              w_branch_inc;
  logic              w_hit_inc;

  // Once in WAIT the request must stay up regardless of ibuffer_full.
  always_comb begin
    w_rreq = 1'b0;
    case (r_state)
      ST_RUN:  w_rreq = !flush && !ibuffer_full;
      ST_WAIT: w_rreq = !flush;
      default: w_rreq = 1'b0;
    endcase
    w_hs = w_rreq && icache_ready;
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (flush) begin
      if (flush_cause == FC_EXCEPTION) begin
        w_pc_nxt = epc;
      end else if (branch_flag) begin
        w_pc_nxt = npc_actual;
      end else begin
        w_pc_nxt = ex_pc + NT_OFFSET;
      end
    end else if (w_hs) begin
      if (pred_valid) begin
        w_pc_nxt = pred_target;
      end else begin
        w_pc_nxt = (r_pc & ~(GROUP_BYTES - ADDR_W'(1))) + GROUP_BYTES;
      end
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = (w_rreq && !icache_ready) ? ST_WAIT : ST_RUN;
        ST_WAIT: w_state_nxt = w_hs ? ST_RUN : ST_WAIT;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  // Slots below the entry offset of the group are not valid.
  always_comb begin
    w_slot = (r_pc >> 2) & SLOT_MASK;
    w_mask = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_mask[i] = (ADDR_W'(i) >= w_slot);
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= ST_BOOT;
      r_pc    <= ENTRY;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign w_branch_inc = resolve_valid && branch_flag;
  assign w_hit_inc    = w_branch_inc && !(flush && (flush_cause == FC_MISPREDICT));

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .i_clk   (clk),
    .i_rst   (resetn),
    .i_clear (1'b0),
    .i_inc   (w_branch_inc),
    .o_count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .i_clk   (clk),
    .i_rst   (resetn),
    .i_clear (1'b0),
    .i_inc   (w_hit_inc),
    .o_count (hit_count)
  );

  assign pc             = r_pc;
  assign rreq_to_icache = w_rreq;
  assign fetch_mask     = w_mask;

endmodule

// File: tb/tb_pc_gen_multi.sv
// Self-checking bench for pc_gen_multi (FETCH_W=2, CNT_W=4, DS_SLOTS=1):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_gen_multi;

  localparam logic [31:0] ENTRY_PC = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        flush_cause;
  logic [31:0] epc;
  logic        resolve_valid;
  logic        branch_flag;
  logic [31:0] npc_actual;
  logic [31:0] ex_pc;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        ibuffer_full;
  logic        icache_ready;
  logic [31:0] pc;
  logic        rreq_to_icache;
  logic [1:0]  fetch_mask;
  logic [3:0]  branch_count;
  logic [3:0]  hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen_multi #(
    .ADDR_W   (32),
    .FETCH_W  (2),
    .ENTRY    (ENTRY_PC),
    .CNT_W    (4),
    .DS_SLOTS (1)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .flush_cause    (flush_cause),
    .epc            (epc),
    .resolve_valid  (resolve_valid),
    .branch_flag    (branch_flag),
    .npc_actual     (npc_actual),
    .ex_pc          (ex_pc),
    .pred_valid     (pred_valid),
    .pred_target    (pred_target),
    .ibuffer_full   (ibuffer_full),
    .icache_ready   (icache_ready),
    .pc             (pc),
    .rreq_to_icache (rreq_to_icache),
    .fetch_mask     (fetch_mask),
    .branch_count   (branch_count),
    .hit_count      (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a fetcher that is booting, or has a request pending
  // that the icache has not yet taken, plus two capped event tallies.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_pend;
  int          m_bc;
  int          m_hc;

  always @(negedge clk) begin
    logic        e_rreq;
    logic        hs;
    logic [1:0]  e_mask;
    int          slot;
    if (resetn) begin
      m_pc   = ENTRY_PC;
      m_boot = 1'b1;
      m_pend = 1'b0;
      m_bc   = 0;
      m_hc   = 0;
      chk("rst_pc", pc, m_pc);
      chk("rst_rreq", rreq_to_icache, 1'b0);
      chk("rst_mask", fetch_mask, 2'b11);
      chk("rst_bc", branch_count, 4'd0);
      chk("rst_hc", hit_count, 4'd0);
    end else begin
      e_rreq = !m_boot && !flush && (m_pend || !ibuffer_full);
      hs     = e_rreq && icache_ready;
      slot   = int'((m_pc / 4) % 2);
      for (int i = 0; i < 2; i++) e_mask[i] = (i >= slot);
      chk("pc", pc, m_pc);
      chk("rreq", rreq_to_icache, e_rreq);
      chk("mask", fetch_mask, e_mask);
      chk("branch_count", branch_count, m_bc);
      chk("hit_count", hit_count, m_hc);
      if (resolve_valid && branch_flag) begin
        if (m_bc < 15) m_bc++;
        if (!(flush && flush_cause) && m_hc < 15) m_hc++;
      end
      if (flush) begin
        if (flush_cause == 1'b0)  m_pc = epc;
        else if (branch_flag)     m_pc = npc_actual;
        else                      m_pc = ex_pc + 32'd8;
      end else if (hs) begin
        if (pred_valid) m_pc = pred_target;
        else            m_pc = (m_pc - (m_pc % 32'd8)) + 32'd8;
      end
      m_pend = !flush && e_rreq && !icache_ready;
      m_boot = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; flush_cause = 1'b0; epc = 32'd0; resolve_valid = 1'b0;
    branch_flag = 1'b0; npc_actual = 32'd0; ex_pc = 32'd0; pred_valid = 1'b0;
    pred_target = 32'd0; ibuffer_full = 1'b0; icache_ready = 1'b1;
  endtask

  initial begin
    resetn = 1'b1;
    idle();
    @(negedge clk);
    chk("boot_pc_lit", pc, 32'hBFC0_0000);
    step(); resetn = 1'b0;
    @(negedge clk); chk("boot_rreq_lit", rreq_to_icache, 1'b0);
    step(); @(negedge clk);
    chk("run0_pc_lit", pc, 32'hBFC0_0000); chk("run0_rreq_lit", rreq_to_icache, 1'b1);
    step(); @(negedge clk); chk("seq1_pc_lit", pc, 32'hBFC0_0008);
    step(); icache_ready = 1'b0; @(negedge clk);
    chk("seq2_pc_lit", pc, 32'hBFC0_0010); chk("wait_rreq_lit", rreq_to_icache, 1'b1);
    step(); ibuffer_full = 1'b1; @(negedge clk);
    chk("wait_full_rreq_lit", rreq_to_icache, 1'b1); chk("wait_pc_lit", pc, 32'hBFC0_0010);
    step(); ibuffer_full = 1'b0; @(negedge clk);
    step(); icache_ready = 1'b1; @(negedge clk);
    chk("wait_hold_pc_lit", pc, 32'hBFC0_0010);
    step(); @(negedge clk); chk("wait_adv_pc_lit", pc, 32'hBFC0_0018);

    step(); flush = 1'b1; flush_cause = 1'b0; epc = 32'h8000_0180;
    resolve_valid = 1'b1; branch_flag = 1'b1; npc_actual = 32'h1234_5678;
    @(negedge clk); chk("exc_rreq_lit", rreq_to_icache, 1'b0);
    step(); flush = 1'b0; resolve_valid = 1'b0; branch_flag = 1'b0;
    @(negedge clk); chk("exc_pc_lit", pc, 32'h8000_0180); chk("exc_rreq1_lit", rreq_to_icache, 1'b1);
    step(); flush = 1'b1; flush_cause = 1'b1; ex_pc = 32'hBFC0_0104;
    @(negedge clk);
    step(); flush = 1'b0; pred_valid = 1'b1; pred_target = 32'hBFC0_0204;
    @(negedge clk); chk("nt_pc_lit", pc, 32'hBFC0_010C); chk("nt_mask_lit", fetch_mask, 2'b10);
    step(); pred_valid = 1'b0;
    @(negedge clk); chk("pred_pc_lit", pc, 32'hBFC0_0204); chk("pred_mask_lit", fetch_mask, 2'b10);
    step(); @(negedge clk); chk("post_pred_pc_lit", pc, 32'hBFC0_0208);

    // Asynchronous reset while a request is stalled
    step(); icache_ready = 1'b0;
    step(); @(negedge clk); chk("pre_rst_rreq_lit", rreq_to_icache, 1'b1);
    step(); #2 resetn = 1'b1;
    #1 chk("async_rreq_lit", rreq_to_icache, 1'b0); chk("async_pc_lit", pc, ENTRY_PC);
    step(); resetn = 1'b0; icache_ready = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      resolve_valid = 1'b1; branch_flag = 1'b1; npc_actual = 32'hBFC0_1000;
      flush = (i < 3); flush_cause = 1'b1;
    end
    step(); idle();
    @(negedge clk); chk("sat_bc_lit", branch_count, 4'd15); chk("sat_hc_lit", hit_count, 4'd15);
    step(); resetn = 1'b1;
    @(negedge clk); chk("clr_bc_lit", branch_count, 4'd0); chk("clr_hc_lit", hit_count, 4'd0);
    step(); resetn = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      step();
      resetn        = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      flush_cause   = 1'($urandom_range(0, 1));
      epc           = $urandom;
      resolve_valid = 1'($urandom_range(0, 1));
      branch_flag   = 1'($urandom_range(0, 1));
      npc_actual    = $urandom;
      ex_pc         = $urandom;
      pred_valid    = ($urandom_range(0, 3) == 0);
      pred_target   = $urandom;
      ibuffer_full  = ($urandom_range(0, 3) == 0);
      icache_ready  = ($urandom_range(0, 2) != 0);
    end
    step(); resetn = 1'b0; idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
